instr_issuer: RTL and testbench

Instruction sequencer that drives the 20-bit `instruction` input of the simple CPU. It stores a small program in an internal RAM and presents each word for exactly as many cycles as the CPU control unit needs to complete that instruction class. It then advances the program counter and reports completion. It sits between the testbench or host loader and `simple_cpu`, and is the producer end of the CPU's instruction interface.

---
 rtl/instr_issuer_pkg.sv | 56 +++++
 rtl/instr_issuer_prog_ram.sv | 37 +++
 rtl/instr_issuer.sv | 192 +++++++++++++++++++
 tb/tb_instr_issuer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issuer_pkg.sv
// -----------------------------------------------------------------------------
// instr_issuer_pkg
// Shared definitions for the instruction issuer: instruction class codes,
// instruction word field layout, per-class hold lengths (in cycles, counted
// from the CPU control unit's DECODE state), the CU's NOP loop length, and
// the issuer state enum.
// -----------------------------------------------------------------------------
package instr_issuer_pkg;

  typedef enum logic [1:0] {
    CLS_NOP    = 2'b00,
    CLS_STD    = 2'b01,
    CLS_LOADR  = 2'b10,
    CLS_STORER = 2'b11
  } instr_class_e;

  // Field layout of a 20-bit instruction word, MSB first.
  typedef struct packed {
    instr_class_e cls;     // [19:18]
    logic [1:0]   x1;      // [17:16]
    logic [1:0]   x2;      // [15:14]
    logic [1:0]   x3;      // [13:12]
    logic [7:0]   offset;  // [11:4]
    logic [3:0]   opcode;  // [3:0]
  } instr_word_t;

  localparam int CLASS_LSB = 18;

  localparam int HOLD_STD    = 3;
  localparam int HOLD_LOADR  = 4;
  localparam int HOLD_STORER = 3;
  localparam int HOLD_NOP    = 4;

  // The CU spins through a 4-cycle loop while it sees NOP words.
  localparam int NOP_SLOT_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_ISSUE,
    ST_FIN
  } state_e;

  // Number of cycles the CU needs to finish an instruction of class cls.
  function automatic logic [2:0] hold_len(input logic [1:0] cls);
    logic [2:0] len;
    case (cls)
      CLS_STD:    len = 3'(HOLD_STD);
      CLS_LOADR:  len = 3'(HOLD_LOADR);
      CLS_STORER: len = 3'(HOLD_STORER);
      default:    len = 3'(HOLD_NOP);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_issuer_prog_ram.sv
// -----------------------------------------------------------------------------
// prog_ram
// Program store for the instruction issuer: (1 << ADDR_BITS) x WIDTH,
// synchronous write, asynchronous read.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
// -----------------------------------------------------------------------------
module prog_ram #(
  parameter int WIDTH     = 20,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the program must survive a CPU reset, and a
  // per-entry reset would turn the RAM into a bank of resettable flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// -----------------------------------------------------------------------------
// instr_issuer
// Drives the simple CPU's instruction input from an internal program RAM.
// Each word is held for as many cycles as the CU needs for its class; the
// very first word after reset is held one extra cycle because the CU only
// leaves RESET once it sees a nonzero class. After the first word has been
// issued, new runs are aligned to the CU's 4-cycle NOP loop.
//
// Optional feature: define INSTR_ISSUER_LOOP_EN to add the `loop` input;
// with loop = 1 the program wraps back to address 0 instead of finishing.
//
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   load_en/addr/data - program RAM write port (ignored while busy)
//   start, prog_len   - run prog_len words from address 0 (accepted in IDLE)
//   loop              - (INSTR_ISSUER_LOOP_EN only) wrap at end of program
//   instruction       - registered word to the CPU, 0 when not issuing
//   issue_strobe      - pulse in the first cycle of each issued word
//   pc                - address of the word on `instruction`
//   busy              - run in progress (through the final hold cycle)
//   done              - pulse in the cycle after the final hold cycle
// -----------------------------------------------------------------------------
module instr_issuer
  import instr_issuer_pkg::*;
#(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [PROG_ADDR_BITS-1:0] load_addr,
  input  logic [INSTR_WIDTH-1:0]    load_data,
  input  logic                      start,
  input  logic [PROG_ADDR_BITS:0]   prog_len,
`ifdef INSTR_ISSUER_LOOP_EN
  input  logic                      loop,
`endif
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      issue_strobe,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  localparam int                    PROG_DEPTH = 1 << PROG_ADDR_BITS;
  localparam logic [PROG_ADDR_BITS:0] LEN_MAX  = (PROG_ADDR_BITS + 1)'(PROG_DEPTH);
  localparam logic [1:0]            SLOT_LAST  = 2'(NOP_SLOT_LEN - 1);

  state_e                    state_q, state_d;
  logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
  logic [PROG_ADDR_BITS:0]   len_q, len_d;
  logic [2:0]                hold_q, hold_d;    // remaining hold cycles - 1
  logic [1:0]                slot_q, slot_d;    // phase within the CU NOP loop
  logic                      primed_q, primed_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic                      strobe_q, strobe_d;

  logic                      ram_we;
  logic [PROG_ADDR_BITS-1:0] rd_addr;
  logic [INSTR_WIDTH-1:0]    ram_rdata;
  logic [INSTR_WIDTH-1:0]    fetch;
  logic [PROG_ADDR_BITS:0]   pc_next;
  logic                      issue_word;

  assign busy   = (state_q == ST_WAIT_SLOT) || (state_q == ST_ISSUE);
  assign ram_we = load_en && !busy;

  prog_ram #(
    .WIDTH     (INSTR_WIDTH),
    .ADDR_BITS (PROG_ADDR_BITS)
  ) u_prog_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // A write landing on the same edge as the fetch must be seen by the issue.
  assign fetch   = (ram_we && (load_addr == rd_addr)) ? load_data : ram_rdata;
  assign pc_next = {1'b0, pc_q} + 1'b1;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    hold_d     = hold_q;
    slot_d     = slot_q;
    primed_d   = primed_q;
    instr_d    = instr_q;
    strobe_d   = 1'b0;
    rd_addr    = '0;
    issue_word = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        instr_d = '0;
        if (primed_q) slot_d = slot_q + 2'd1;
        if (start) begin
          len_d = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
          pc_d  = '0;
          if (prog_len == '0)                        state_d    = ST_FIN;
          else if (!primed_q || slot_q == SLOT_LAST) issue_word = 1'b1;
          else                                       state_d    = ST_WAIT_SLOT;
        end
      end

      ST_WAIT_SLOT: begin
        slot_d = slot_q + 2'd1;
        // Launch on the edge that closes the current NOP slot.
        if (slot_q == SLOT_LAST) issue_word = 1'b1;
      end

      ST_ISSUE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 3'd1;
        end else if (pc_next < len_q) begin
          rd_addr    = pc_next[PROG_ADDR_BITS-1:0];
          pc_d       = pc_next[PROG_ADDR_BITS-1:0];
          issue_word = 1'b1;
        end
`ifdef INSTR_ISSUER_LOOP_EN
        else if (loop) begin
          rd_addr    = '0;
          pc_d       = '0;
          issue_word = 1'b1;
        end
`endif
        else begin
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        // The FIN cycle is slot 0 of the CU's NOP loop.
        slot_d  = slot_q + 2'd1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (issue_word) begin
      state_d  = ST_ISSUE;
      instr_d  = fetch;
      strobe_d = 1'b1;
      // Unprimed: the extra cycle the CU spends leaving RESET.
      hold_d   = hold_len(fetch[CLASS_LSB +: 2]) - {2'b00, primed_q};
      primed_d = 1'b1;
    end

    if (state_d == ST_FIN) begin
      instr_d = '0;
      pc_d    = '0;
      slot_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      hold_q   <= '0;
      slot_q   <= '0;
      primed_q <= 1'b0;
      instr_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      hold_q   <= hold_d;
      slot_q   <= slot_d;
      primed_q <= primed_d;
      instr_q  <= instr_d;
      strobe_q <= strobe_d;
    end
  end

  assign instruction  = instr_q;
  assign issue_strobe = strobe_q;
  assign pc           = pc_q;
  assign done         = (state_q == ST_FIN);

endmodule

// File: tb/tb_instr_issuer.sv
// -----------------------------------------------------------------------------
// tb_instr_issuer
// Self-checking bench for instr_issuer. A reference model turns the program
// image, the primed flag and the NOP-loop phase into the expected per-cycle
// output trace of each run, which is compared cycle by cycle. Directed steps
// cover the reset state, the documented examples, slot alignment, an empty
// program and a mid-run reset; randomized runs follow.
// -----------------------------------------------------------------------------
module tb_instr_issuer;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [19:0] load_data;
  logic        start;
  logic [4:0]  prog_len;
  logic [19:0] instruction;
  logic        issue_strobe;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
`ifdef INSTR_ISSUER_LOOP_EN
  logic        loop;
`endif

  instr_issuer dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .prog_len     (prog_len),
`ifdef INSTR_ISSUER_LOOP_EN
    .loop         (loop),
`endif
    .instruction  (instruction),
    .issue_strobe (issue_strobe),
    .pc           (pc),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] instr;
    logic        strobe;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
  } exp_t;

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state.
  logic [19:0] model_mem [16];
  bit          model_primed;
  int          last_done;            // cycle index of the latest done pulse
  int          hold_tbl [4] = '{4, 3, 4, 3};  // NOP, std_op, loadR, storeR
  exp_t        exp_q [$];

  // Observations from the latest run.
  int          strobe_offs [$];
  int          done_off;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [19:0] instr, input logic strobe,
                              input logic [3:0] p, input logic b, input logic d);
    exp_t e;
    e.instr  = instr;
    e.strobe = strobe;
    e.pc     = p;
    e.busy   = b;
    e.done   = d;
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".instruction"},  32'(instruction),  32'(e.instr));
    check({tag, ".issue_strobe"}, 32'(issue_strobe), 32'(e.strobe));
    check({tag, ".pc"},           32'(pc),           32'(e.pc));
    check({tag, ".busy"},         32'(busy),         32'(e.busy));
    check({tag, ".done"},         32'(done),         32'(e.done));
  endtask

  // One clock: inputs were set before the rising edge, outputs are sampled
  // on the following falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Expected outputs for cycles s+1 .. done, for a start driven in cycle s.
  function automatic void build_trace(input int s, input int len);
    int n;
    int first;
    int hold;
    n = (len > 16) ? 16 : len;
    exp_q.delete();
    if (n == 0) begin
      exp_q.push_back(mk(20'h0, 1'b0, 4'h0, 1'b0, 1'b1));
      last_done = s + 1;
      return;
    end
    // Primed: first word lands on the first NOP-slot boundary after start.
    first = s + 1;
    if (model_primed)
      while (((first - last_done) % 4) != 0) first++;
    for (int c = s + 1; c < first; c++)
      exp_q.push_back(mk(20'h0, 1'b0, 4'h0, 1'b1, 1'b0));
    for (int w = 0; w < n; w++) begin
      hold = hold_tbl[model_mem[w][19:18]] + ((w == 0 && !model_primed) ? 1 : 0);
      for (int h = 0; h < hold; h++)
        exp_q.push_back(mk(model_mem[w], h == 0, 4'(w), 1'b1, 1'b0));
    end
    exp_q.push_back(mk(20'h0, 1'b0, 4'h0, 1'b0, 1'b1));
    model_primed = 1'b1;
    last_done    = s + exp_q.size();
  endfunction

  task automatic check_idle(input string tag);
    check_out(tag, mk(20'h0, 1'b0, 4'h0, 1'b0, 1'b0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start   = 1'b0;
      load_en = 1'b0;
      tick();
      check_idle("idle");
    end
  endtask

  task automatic load_word(input logic [3:0] a, input logic [19:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    model_mem[a] = d;
    tick();
    load_en = 1'b0;
    check_idle("load");
  endtask

  // Start a run in the current cycle and check it through its done pulse.
  // with_load: write a random word in the start cycle (must be visible).
  // junk: toggle start/load_en while busy (both must be ignored).
  task automatic run(input int len, input bit with_load, input bit junk);
    int   s;
    exp_t e;
    s        = cyc;
    start    = 1'b1;
    prog_len = 5'(len);
    if (with_load) begin
      load_en   = 1'b1;
      load_addr = 4'($urandom);
      load_data = 20'($urandom);
      model_mem[load_addr] = load_data;
    end
    build_trace(s, len);
    strobe_offs.delete();
    done_off = -1;
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      e        = exp_q[i];
      start    = 1'b0;
      load_en  = 1'b0;
      prog_len = 5'($urandom);
      check_out($sformatf("run+%0d", cyc - s), e);
      if (issue_strobe) strobe_offs.push_back(cyc - s);
      if (done && done_off < 0) done_off = cyc - s;
      if (junk && e.busy) begin
        start     = 1'($urandom);
        load_en   = 1'($urandom);
        load_addr = 4'($urandom);
        load_data = 20'($urandom);
      end
      if (i < exp_q.size() - 1) tick();
    end
    start   = 1'b0;
    load_en = 1'b0;
  endtask

  initial begin
    bit seen;
    rst       = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    start     = 1'b0;
    prog_len  = '0;
`ifdef INSTR_ISSUER_LOOP_EN
    loop      = 1'b0;
`endif
    model_primed = 1'b0;
    last_done    = 0;

    // Reset state, held and then released.
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    rst = 1'b1;
    idle(4);

    // Fill the whole program RAM so every address has a known value.
    for (int i = 0; i < 16; i++) load_word(4'(i), 20'($urandom));

    // Single std_op, unprimed: 4 cycles of the word, done in the 5th.
    load_word(4'd0, 20'h58000);
    run(1, 1'b0, 1'b0);
    check("d1.strobes", 32'(strobe_offs.size()), 32'd1);
    check("d1.done_off", 32'(done_off), 32'd5);

    // Mixed program, primed: holds 3, 4, 3.
    load_word(4'd1, 20'h94010);
    load_word(4'd2, 20'hF8020);
    run(3, 1'b0, 1'b0);
    check("d2.strobes", 32'(strobe_offs.size()), 32'd3);
    if (strobe_offs.size() == 3) begin
      check("d2.strobe1", 32'(strobe_offs[1] - strobe_offs[0]), 32'd3);
      check("d2.strobe2", 32'(strobe_offs[2] - strobe_offs[0]), 32'd7);
      check("d2.done",    32'(done_off - strobe_offs[0]),       32'd10);
    end

    // Alignment: start two cycles into the NOP slot after done.
    idle(2);
    run(3, 1'b0, 1'b0);
    check("d3.first_word", 32'(strobe_offs.size() > 0 ? strobe_offs[0] : -1), 32'd2);

    // Empty program: done next cycle, nothing issued.
    idle(1);
    run(0, 1'b0, 1'b0);
    check("d4.done_off", 32'(done_off), 32'd1);
    check("d4.strobes",  32'(strobe_offs.size()), 32'd0);

    // Reset in the middle of a loadR hold.
    load_word(4'd0, 20'h94010);
    start    = 1'b1;
    prog_len = 5'd1;
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (issue_strobe) seen = 1'b1;
      else tick();
    end
    check("d5.issued", 32'(seen), 32'd1);
    check("d5.word", 32'(instruction), 32'h94010);
    tick();
    #2 rst = 1'b0;
    #1 check_idle("d5.async_rst");
    tick();
    rst = 1'b1;
    model_primed = 1'b0;
    idle(2);
    run(1, 1'b0, 1'b0);
    check("d5.unprimed_done", 32'(done_off), 32'd6);

    // Randomized runs: program edits, gaps, lengths (incl. > 16), same-cycle
    // loads and ignored start/load activity while busy.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(2, 0) == 0)
        for (int k = 0; k < int'($urandom_range(3, 1)); k++)
          load_word(4'($urandom), 20'($urandom));
      idle(int'($urandom_range(5, 1)));
      run(int'($urandom_range(20, 0)), 1'($urandom), 1'b1);
    end

`ifdef INSTR_ISSUER_LOOP_EN
    begin
      int pcs [$];
      idle(1);
      loop     = 1'b1;
      start    = 1'b1;
      prog_len = 5'd2;
      tick();
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (issue_strobe) pcs.push_back(int'(pc));
        check("loop.no_done", 32'(done), 32'd0);
        tick();
      end
      check("loop.passes", 32'(pcs.size() >= 6), 32'd1);
      for (int i = 0; i < 6 && i < pcs.size(); i++)
        check("loop.pc_seq", 32'(pcs[i]), 32'(i % 2));
      loop = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        if (done) seen = 1'b1;
        else tick();
      end
      check("loop.done_after_drop", 32'(seen), 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
